// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared image defaults and frame-source state encoding for the canny stages
package canny_pkg;

    // Frame geometry shared by the reader and the filter stages.
    localparam int IMG_WIDTH    = 1280;
    localparam int IMG_HEIGHT   = 720;

    // One 32-bit frame-buffer word carries four 8-bit pixels, byte0 first.
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EMIT,
        DONE
    } src_state_t;

endpackage

// File: rtl/frame_stream_source.sv
// rtl/frame_stream_source.sv - frame-buffer reader that unpacks words into the 8-bit pixel FIFO
module frame_stream_source
    import canny_pkg::*;
#(
    parameter int                WIDTH     = IMG_WIDTH,
    parameter int                HEIGHT    = IMG_HEIGHT,
    parameter int                ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              out_wr_en,
    input  logic              out_full,
    output logic [7:0]        out_din
);

    localparam int TOTAL  = WIDTH * HEIGHT;
    localparam int PIX_W  = $clog2(TOTAL + 1);
    localparam int BYTE_W = $clog2(PIX_PER_WORD);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(TOTAL - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PIX_PER_WORD - 1);

    // A frame must end on a whole word, and the word counter must reach every word.
    generate
        if (TOTAL % PIX_PER_WORD != 0) begin : g_bad_frame_size
            $error("frame_stream_source: WIDTH*HEIGHT must be a multiple of 4");
        end
        if (ADDR_W < $clog2(TOTAL / PIX_PER_WORD)) begin : g_bad_addr_w
            $error("frame_stream_source: ADDR_W too narrow for the frame");
        end
    endgenerate

    src_state_t          state_q,    state_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [PIX_W-1:0]    pix_cnt_q,  pix_cnt_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [31:0]         word_q,     word_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    // Next-state: fetch a word, emit its four bytes under FIFO backpressure, repeat to frame end.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = REQ;
                    word_cnt_d = '0;
                    pix_cnt_d  = '0;
                    mem_addr_d = BASE_ADDR;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                word_d     = mem_rdata;
                byte_idx_d = '0;
                state_d    = EMIT;
            end
            EMIT: begin
                // A full FIFO freezes everything: no write, same byte next cycle.
                if (!out_full) begin
                    pix_cnt_d  = pix_cnt_q + 1'b1;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == LAST_BYTE) begin
                        if (pix_cnt_q == LAST_PIX) begin
                            state_d = DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                            // Address is loaded on entry to REQ and simply held afterwards.
                            mem_addr_d = BASE_ADDR + word_cnt_q + 1'b1;
                            state_d    = REQ;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and the captured word; reset drops any frame in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            pix_cnt_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            mem_addr_q <= BASE_ADDR;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_rd_en = (state_q == REQ);
    assign mem_addr  = mem_addr_q;
    // The write strobe must drop in the same cycle the FIFO reports full.
    assign out_wr_en = (state_q == EMIT) && !out_full;
    assign out_din   = word_q[{byte_idx_q, 3'b000} +: 8];

endmodule

// File: tb/tb_frame_stream_source.sv
// tb/tb_frame_stream_source.sv - self-checking bench for frame_stream_source
module tb_frame_stream_source;

    localparam int              AW_A   = 10;
    localparam logic [AW_A-1:0] BASE_A = 10'h100;
    localparam int              W_B    = 12;
    localparam int              H_B    = 8;
    localparam int              AW_B   = 5;
    localparam logic [AW_B-1:0] BASE_B = 5'h1C;
    localparam int              NPIX_B = W_B * H_B;
    localparam int              NWRD_B = NPIX_B / 4;

    logic clock;
    logic reset;

    logic            start_a, busy_a, done_a, mem_rd_en_a, out_wr_en_a, out_full_a;
    logic [AW_A-1:0] mem_addr_a;
    logic [31:0]     mem_rdata_a;
    logic [7:0]      out_din_a;

    logic            start_b, busy_b, done_b, mem_rd_en_b, out_wr_en_b, out_full_b;
    logic [AW_B-1:0] mem_addr_b;
    logic [31:0]     mem_rdata_b;
    logic [7:0]      out_din_b;

    frame_stream_source #(.WIDTH(4), .HEIGHT(2), .ADDR_W(AW_A), .BASE_ADDR(BASE_A)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_addr(mem_addr_a), .mem_rd_en(mem_rd_en_a), .mem_rdata(mem_rdata_a),
        .out_wr_en(out_wr_en_a), .out_full(out_full_a), .out_din(out_din_a)
    );

    frame_stream_source #(.WIDTH(W_B), .HEIGHT(H_B), .ADDR_W(AW_B), .BASE_ADDR(BASE_B)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_addr(mem_addr_b), .mem_rd_en(mem_rd_en_b), .mem_rdata(mem_rdata_b),
        .out_wr_en(out_wr_en_b), .out_full(out_full_b), .out_din(out_din_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Frame-buffer models: read data appears one cycle after the strobe.
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:31];
    always @(posedge clock) begin
        if (mem_rd_en_a) mem_rdata_a <= mem_a[mem_addr_a];
        if (mem_rd_en_b) mem_rdata_b <= mem_b[mem_addr_b];
    end

    // Observation logs, sampled mid-cycle; a write seen here lands on the next rising edge.
    logic [7:0]      wr_a[$];
    int              wrc_a[$];
    logic [AW_A-1:0] rda_a[$];
    int              rdc_a[$];
    int              done_n_a = 0;
    int              done_c_a = -1;
    int              viol_a   = 0;
    logic [7:0]      wr_b[$];
    logic [AW_B-1:0] rda_b[$];
    int              done_n_b = 0;
    int              viol_b   = 0;

    always @(negedge clock) begin
        if (out_wr_en_a) begin
            wr_a.push_back(out_din_a);
            wrc_a.push_back(cyc);
            if (out_full_a) viol_a++;
        end
        if (mem_rd_en_a) begin
            rda_a.push_back(mem_addr_a);
            rdc_a.push_back(cyc);
        end
        if (done_a) begin
            done_n_a++;
            done_c_a = cyc;
        end
        if (out_wr_en_b) begin
            wr_b.push_back(out_din_b);
            if (out_full_b) viol_b++;
        end
        if (mem_rd_en_b) rda_b.push_back(mem_addr_b);
        if (done_b) done_n_b++;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Runs one frame on dut_a; optional full window [flo,fhi) in cycles after start,
    // and optional stray starts mid-frame and in the done cycle.
    task automatic run_a(input int flo, input int fhi, input bit pmid, input bit pdone,
                         output int s, output int e, output logic b1);
        int off;
        s = cyc;
        e = -1;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        b1 = busy_a;
        for (int k = 0; k < 300; k++) begin
            off = cyc - s;
            out_full_a = (off >= flo) && (off < fhi);
            start_a    = (pmid && off == 5) || (pdone && done_a);
            if (!busy_a && !start_a) begin
                e = cyc;
                break;
            end
            tick(1);
        end
        out_full_a = 1'b0;
        start_a    = 1'b0;
        check("run_a_timeout", 32'(e < 0), 0);
    endtask

    task automatic run_b(output int e);
        e = -1;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            out_full_b = 1'($urandom_range(0, 1));
            if (!busy_b) begin
                e = cyc;
                break;
            end
            tick(1);
        end
        out_full_b = 1'b0;
        check("run_b_timeout", 32'(e < 0), 0);
    endtask

    // Checks the eight pixels 00..07 of the small frame starting at log index wb.
    task automatic check_small(input string tag, input int wb);
        check({tag, "_nwr"}, wr_a.size() - wb, 8);
        for (int i = 0; i < 8 && wb + i < wr_a.size(); i++)
            check({tag, "_pix"}, wr_a[wb + i], i);
    endtask

    initial begin
        int s, e, wb, rb, db, vb, bb, sum_got, sum_exp;
        logic b1;
        logic [7:0] exp_b[$];
        logic [31:0] w;

        reset = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        out_full_a = 1'b0; out_full_b = 1'b0;
        for (int i = 0; i < 1024; i++) mem_a[i] = 32'h0;
        for (int i = 0; i < 32; i++) mem_b[i] = 32'h0;
        mem_a[BASE_A]     = 32'h03020100;
        mem_a[BASE_A + 1] = 32'h07060504;

        tick(3);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rd_en", mem_rd_en_a, 0);
        check("rst_wr_en", out_wr_en_a, 0);
        check("rst_addr", mem_addr_a, BASE_A);
        check("rst_din", out_din_a, 0);
        check("rst_addr_b", mem_addr_b, BASE_B);
        check("rst_busy_b", busy_b, 0);
        reset = 1'b1;
        tick(2);

        // Small frame, no backpressure: order, latency, throughput, reads, done/busy timing.
        wb = wr_a.size(); rb = rda_a.size(); db = done_n_a;
        run_a(0, 0, 1'b0, 1'b0, s, e, b1);
        check_small("t1", wb);
        check("t1_busy_after_start", b1, 1);
        if (wr_a.size() >= wb + 8) begin
            check("t1_first_lat", wrc_a[wb] - s, 3);
            check("t1_last_wr", wrc_a[wb + 7] - s, 12);
            check("t1_done_cyc", done_c_a - s, 13);
        end
        check("t1_done_n", done_n_a - db, 1);
        check("t1_busy_fall", e - s, 14);
        check("t3_nrd", rda_a.size() - rb, 2);
        if (rda_a.size() >= rb + 2) begin
            check("t3_addr0", rda_a[rb], BASE_A);
            check("t3_addr1", rda_a[rb + 1], BASE_A + 1);
            check("t3_rd0_cyc", rdc_a[rb] - s, 1);
            check("t3_rd1_cyc", rdc_a[rb + 1] - s, 7);
        end
        check("t3_addr_hold", mem_addr_a, BASE_A + 1);

        // Full for five cycles while byte 2 of word 0 is pending.
        tick(2);
        wb = wr_a.size(); db = done_n_a; vb = viol_a;
        run_a(5, 10, 1'b0, 1'b0, s, e, b1);
        check_small("t2", wb);
        if (wr_a.size() >= wb + 8) begin
            check("t2_byte1_cyc", wrc_a[wb + 1] - s, 4);
            check("t2_byte2_cyc", wrc_a[wb + 2] - s, 10);
            check("t2_last_wr", wrc_a[wb + 7] - s, 17);
        end
        check("t2_no_wr_when_full", viol_a - vb, 0);
        check("t2_done_n", done_n_a - db, 1);

        // Stray starts mid-frame and in the done cycle are ignored.
        tick(2);
        wb = wr_a.size(); db = done_n_a;
        run_a(0, 0, 1'b1, 1'b1, s, e, b1);
        tick(10);
        check_small("t4", wb);
        if (wr_a.size() >= wb + 8) check("t4_last_wr", wrc_a[wb + 7] - s, 12);
        check("t4_done_n", done_n_a - db, 1);
        check("t4_idle_after", busy_a, 0);

        // Reset during word 1 emission, then a clean replay.
        tick(2);
        wb = wr_a.size(); db = done_n_a;
        s = cyc;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(9);
        reset = 1'b0;
        #1;
        check("t5_nwr_before_rst", wr_a.size() - wb, 5);
        check("t5_busy", busy_a, 0);
        check("t5_done", done_a, 0);
        check("t5_wr_en", out_wr_en_a, 0);
        check("t5_rd_en", mem_rd_en_a, 0);
        check("t5_din", out_din_a, 0);
        check("t5_addr", mem_addr_a, BASE_A);
        tick(2);
        reset = 1'b1;
        tick(2);
        check("t5_no_done_on_abort", done_n_a - db, 0);
        wb = wr_a.size();
        run_a(0, 0, 1'b0, 1'b0, s, e, b1);
        check_small("t5", wb);
        check("t5_done_n", done_n_a - db, 1);

        // Larger frame with a wrapping base address, random data, random backpressure.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 32; i++) mem_b[i] = $urandom;
            exp_b.delete();
            sum_exp = 0;
            for (int p = 0; p < NPIX_B; p++) begin
                w = mem_b[(int'(BASE_B) + p / 4) % 32];
                exp_b.push_back(8'(w >> (8 * (p % 4))));
                sum_exp += int'(exp_b[p]);
            end
            tick(2);
            wb = wr_b.size(); rb = rda_b.size(); db = done_n_b; vb = viol_b; bb = 0;
            run_b(e);
            check("t6_nwr", wr_b.size() - wb, NPIX_B);
            sum_got = 0;
            for (int p = 0; p < NPIX_B && wb + p < wr_b.size(); p++) begin
                check("t6_pix", wr_b[wb + p], exp_b[p]);
                sum_got += int'(wr_b[wb + p]);
            end
            check("t6_checksum", sum_got, sum_exp);
            check("t6_nrd", rda_b.size() - rb, NWRD_B);
            for (int k = 0; k < NWRD_B && rb + k < rda_b.size(); k++)
                if (rda_b[rb + k] != AW_B'((int'(BASE_B) + k) % 32)) bb++;
            check("t6_addr_seq_errs", bb, 0);
            check("t6_no_wr_when_full", viol_b - vb, 0);
            check("t6_done_n", done_n_b - db, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
